// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared defaults and stall FSM encoding for the pipeline drain buffer.
package pipeline_pkg;
  localparam int DATA_W_DEF  = 32;
  localparam int DEPTH_DEF   = 8;
  localparam int HIGH_WM_DEF = 6;
  localparam int LOW_WM_DEF  = 2;
  typedef enum logic {RUN, HOLD} stall_state_e;
endpackage

// File: rtl/drain_fifo_mem.sv
// drain_fifo_mem: DEPTH x DATA_W storage, synchronous write, asynchronous read, contents not reset.
module drain_fifo_mem
  import pipeline_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/pipeline_drain_buffer.sv
// pipeline_drain_buffer: FWFT drain FIFO for pipeline stage 3 with watermark-hysteresis global stall.
module pipeline_drain_buffer
  import pipeline_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int HIGH_WM = HIGH_WM_DEF,
  parameter int LOW_WM  = LOW_WM_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  input  logic                     flush,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     stall,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [LW-1:0] level_q, level_d;
  stall_state_e state_q, state_d;
  logic ovf_q, ovf_d;
  logic full, pop, push, drop;
  logic [DATA_W-1:0] head;
  drain_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .we_i    (push & ~flush),
    .waddr_i (wr_q),
    .wdata_i (in_data),
    .raddr_i (rd_q),
    .rdata_o (head)
  );
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  always_comb begin
    full    = level_q == LW'(DEPTH);
    pop     = out_valid & out_ready;
    push    = in_valid & (~full | pop);
    drop    = in_valid & full & ~pop;
    wr_d    = flush ? '0 : wr_q + AW'(push);
    rd_d    = flush ? '0 : rd_q + AW'(pop);
    level_d = flush ? '0 : level_q + LW'(push) - LW'(pop);
    ovf_d   = ovf_q | (drop & ~flush);
    state_d = flush ? RUN
            : (state_q == RUN) ? ((level_d >= LW'(HIGH_WM)) ? HOLD : RUN)
            : ((level_d <= LW'(LOW_WM)) ? RUN : HOLD);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      level_q <= '0;
      state_q <= RUN;
      ovf_q   <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      level_q <= level_d;
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end
  assign out_valid = level_q != '0;
  assign out_data  = out_valid ? head : '0;
  assign stall     = state_q == HOLD;
  assign level     = level_q;
  assign overflow  = ovf_q;
endmodule
